// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC controller for the 16-bit fetch stage.
// It owns the program counter, drives the synchronous text-memory read
// address and enable, and tags the word returned each cycle as valid or
// squashed.
//
// Optional feature: define FETCH_SEQ_TRAP_EN to add the trap_req/trap_ack
// ports. A trap is taken ahead of any branch and redirects fetch to TRAP_VEC.
//
// Stall handling: on the edge that first sees stall in RUN, the presented
// word (ir_pc/ir_valid) is held and pc is not advanced. The word read from pc
// during that cycle is never presented; it is fetched again when the block
// leaves STALL, so no address is skipped or duplicated.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] TRAP_VEC = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt,
  input  logic        resume,
`ifdef FETCH_SEQ_TRAP_EN
  input  logic        trap_req,
  output logic        trap_ack,
`endif
  output logic [15:0] imem_addr,
  output logic        imem_en,
  output logic        ir_valid,
  output logic [15:0] ir_pc,
  output logic [15:0] link_pc,
  output logic [1:0]  seq_state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        trap_in;
  logic        trap_take;
  logic [15:0] branch_pc;

`ifdef FETCH_SEQ_TRAP_EN
  assign trap_in = trap_req;
`else
  assign trap_in = 1'b0;
`endif

  // Branch targets are halfword aligned; bit 0 of the request is dropped.
  assign branch_pc = {branch_target[15:1], 1'b0};

  // A trap is only accepted while fetching or stalled.
  assign trap_take = trap_in & ((state_q == RUN) | (state_q == STALL));

  // Next-state and next-PC selection by state and request priority.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        ir_valid_d = 1'b0;
      end
      RUN: begin
        if (trap_take) begin
          pc_d       = TRAP_VEC;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_d       = branch_pc;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b0;
        end else if (halt) begin
          // The word read at pc is dropped and refetched after resume.
          ir_valid_d = 1'b0;
          state_d    = HALTED;
        end else if (stall) begin
          state_d = STALL;
        end else begin
          pc_d       = pc_q + 16'd2;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
        end
      end
      STALL: begin
        if (trap_take) begin
          pc_d       = TRAP_VEC;
          ir_valid_d = 1'b0;
          state_d    = RUN;
        end else if (branch_taken) begin
          pc_d       = branch_pc;
          ir_valid_d = 1'b0;
          state_d    = RUN;
        end else if (!stall) begin
          state_d = RUN;
        end
      end
      HALTED: begin
        ir_valid_d = 1'b0;
        if (resume) begin
          state_d = BOOT;
        end
      end
      default: begin
        state_d    = BOOT;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer state, program counter and presented-word registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef FETCH_SEQ_TRAP_EN
  logic trap_ack_q, trap_ack_d;

  // Acknowledge each accepted trap with a single-cycle pulse.
  always_comb begin
    trap_ack_d = trap_take;
  end

  // Registered trap acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_ack_q <= 1'b0;
    end else begin
      trap_ack_q <= trap_ack_d;
    end
  end

  assign trap_ack = trap_ack_q;
`endif

  // Memory enable is low while reset is asserted even though state reads BOOT.
  assign imem_en   = reset & ((state_q == BOOT) | (state_q == RUN));
  assign imem_addr = pc_q;
  assign ir_valid  = ir_valid_q;
  assign ir_pc     = ir_pc_q;
  assign link_pc   = ir_pc_q + 16'd2;
  assign seq_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of per-cycle inputs and
// expected outputs, followed by hand-written reset and trap sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic        resume;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic        ir_valid;
  logic [15:0] ir_pc;
  logic [15:0] link_pc;
  logic [1:0]  seq_state;
`ifdef FETCH_SEQ_TRAP_EN
  logic        trap_req;
  logic        trap_ack;
`endif

  int errors;
  int checks;

  fetch_sequencer #(
    .RESET_PC(16'h0000),
    .TRAP_VEC(16'h0010)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt         (halt),
    .resume       (resume),
`ifdef FETCH_SEQ_TRAP_EN
    .trap_req     (trap_req),
    .trap_ack     (trap_ack),
`endif
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .ir_valid     (ir_valid),
    .ir_pc        (ir_pc),
    .link_pc      (link_pc),
    .seq_state    (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        halt;
    logic        resume;
    logic [1:0]  st;
    logic        irv;
    logic [15:0] irpc;
    logic        en;
    logic [15:0] addr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic b, input logic [15:0] t,
                     input logic h, input logic r, input logic [1:0] st,
                     input logic v, input logic [15:0] ip, input logic en,
                     input logic [15:0] ad);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.halt = h; x.resume = r;
    x.st = st; x.irv = v; x.irpc = ip; x.en = en; x.addr = ad;
    vq.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic v,
                         input logic [15:0] ip, input logic en, input logic [15:0] ad);
    logic [15:0] lk;
    lk = ip + 16'd2;
    chk({tag, ".seq_state"}, {14'd0, seq_state}, {14'd0, st});
    chk({tag, ".ir_valid"},  {15'd0, ir_valid},  {15'd0, v});
    chk({tag, ".ir_pc"},     ir_pc,              ip);
    chk({tag, ".imem_en"},   {15'd0, imem_en},   {15'd0, en});
    chk({tag, ".imem_addr"}, imem_addr,          ad);
    chk({tag, ".link_pc"},   link_pc,            lk);
  endtask

  task automatic drive_idle();
    stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    halt = 1'b0; resume = 1'b0;
`ifdef FETCH_SEQ_TRAP_EN
    trap_req = 1'b0;
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive_idle();

    //   stall br  target    halt res | st irv ir_pc    en addr
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h0000, 1, 16'h0000); // c0 BOOT
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0000, 1, 16'h0000);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'h0000, 1, 16'h0002);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'h0002, 1, 16'h0004);
    add(0, 1, 16'h0041, 0, 0,   1, 1, 16'h0004, 1, 16'h0006); // branch at pc 0006
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0006, 1, 16'h0040); // bubble
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'h0040, 1, 16'h0042);
    add(0, 1, 16'h0008, 0, 0,   1, 1, 16'h0042, 1, 16'h0044);
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0044, 1, 16'h0008);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'h0008, 1, 16'h000A);
    add(1, 0, 16'h0000, 0, 0,   1, 1, 16'h000A, 1, 16'h000C); // stall x3
    add(1, 0, 16'h0000, 0, 0,   2, 1, 16'h000A, 0, 16'h000C);
    add(1, 0, 16'h0000, 0, 0,   2, 1, 16'h000A, 0, 16'h000C);
    add(0, 0, 16'h0000, 0, 0,   2, 1, 16'h000A, 0, 16'h000C);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'h000A, 1, 16'h000C);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'h000C, 1, 16'h000E);
    add(0, 0, 16'h0000, 1, 0,   1, 1, 16'h000E, 1, 16'h0010); // halt at pc 0010
    add(0, 0, 16'h0000, 0, 0,   3, 0, 16'h000E, 0, 16'h0010);
    add(0, 1, 16'h0100, 0, 0,   3, 0, 16'h000E, 0, 16'h0010); // branch ignored
    add(0, 0, 16'h0000, 0, 0,   3, 0, 16'h000E, 0, 16'h0010);
    add(0, 0, 16'h0000, 0, 0,   3, 0, 16'h000E, 0, 16'h0010);
    add(0, 0, 16'h0000, 0, 1,   3, 0, 16'h000E, 0, 16'h0010); // resume
    add(0, 0, 16'h0000, 0, 0,   0, 0, 16'h000E, 1, 16'h0010);
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h000E, 1, 16'h0010);
    add(1, 1, 16'hFFFC, 1, 0,   1, 1, 16'h0010, 1, 16'h0012); // branch beats stall+halt
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0012, 1, 16'hFFFC);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'hFFFC, 1, 16'hFFFE);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'hFFFE, 1, 16'h0000); // wrap, link 0000
    add(1, 0, 16'h0000, 0, 0,   1, 1, 16'h0000, 1, 16'h0002);
    add(1, 1, 16'h0021, 0, 0,   2, 1, 16'h0000, 0, 16'h0002); // branch in STALL
    add(0, 0, 16'h0000, 0, 0,   1, 0, 16'h0000, 1, 16'h0020);
    add(0, 0, 16'h0000, 0, 0,   1, 1, 16'h0020, 1, 16'h0022);

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk_all("rst", 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
`ifdef FETCH_SEQ_TRAP_EN
    chk("rst.trap_ack", {15'd0, trap_ack}, 16'h0000);
`endif

    reset = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      #1;
      chk_all($sformatf("c%0d", i), vq[i].st, vq[i].irv, vq[i].irpc, vq[i].en, vq[i].addr);
      stall = vq[i].stall; branch_taken = vq[i].br; branch_target = vq[i].tgt;
      halt = vq[i].halt; resume = vq[i].resume;
      @(negedge clk);
    end

    // Asynchronous reset mid-sequence: outputs return without a clock edge.
    drive_idle();
    #2;
    reset = 1'b0;
    #1;
    chk_all("arst", 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    chk_all("arst_hold", 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    reset = 1'b1;
    #1;
    chk_all("rel_boot", 2'd0, 1'b0, 16'h0000, 1'b0 | 1'b1, 16'h0000);
    @(negedge clk);
    chk_all("rel_run", 2'd1, 1'b0, 16'h0000, 1'b1, 16'h0000);
    @(negedge clk);
    chk_all("rel_w0", 2'd1, 1'b1, 16'h0000, 1'b1, 16'h0002);

`ifdef FETCH_SEQ_TRAP_EN
    // Trap and branch together: trap wins, one ack pulse, one bubble.
    trap_req = 1'b1; branch_taken = 1'b1; branch_target = 16'h0080;
    @(negedge clk);
    trap_req = 1'b0; branch_taken = 1'b0;
    #1;
    chk("trap.ack", {15'd0, trap_ack}, 16'h0001);
    chk_all("trap.bubble", 2'd1, 1'b0, 16'h0002, 1'b1, 16'h0010);
    @(negedge clk);
    #1;
    chk("trap.ack_low", {15'd0, trap_ack}, 16'h0000);
    chk_all("trap.vec", 2'd1, 1'b1, 16'h0010, 1'b1, 16'h0012);
    // Reset during trap activity clears the acknowledge too.
    trap_req = 1'b1;
    @(negedge clk);
    #1;
    chk("trap.ack2", {15'd0, trap_ack}, 16'h0001);
    reset = 1'b0;
    #1;
    chk("trap.ack_rst", {15'd0, trap_ack}, 16'h0000);
    chk_all("trap.rst", 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    trap_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
